// File: rtl/alu_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_writeback: ALU result FIFO for register-file writeback plus the Z/C/N  |
// | flag register and ALU carry-in select. Optional: ALU_WB_OVERFLOW_EN (V).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int DST_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        OP,
  input  logic              USE_CARRY,
  output logic              ALU_C_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] RESULT,
  input  logic              Z_IN,
  input  logic              C_IN_FLAG,
  input  logic              N_IN,
  input  logic              FLAGS_WE,
  input  logic [DST_W-1:0]  DST,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [DST_W-1:0]  OUT_DST,
`ifdef ALU_WB_OVERFLOW_EN
  input  logic              A_MSB,
  input  logic              B_MSB,
  output logic              FLAG_V,
`endif
  output logic              FLAG_Z,
  output logic              FLAG_C,
  output logic              FLAG_N
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DST_W-1:0]  dst_q  [DEPTH];
  logic [DST_W-1:0]  dst_d  [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              flag_n_q, flag_n_d;
  logic              push;
  logic              pop;

  always_comb begin
    IN_READY  = (count_q != FULL_CNT);
    OUT_VALID = (count_q != '0);
    OUT_DATA  = data_q[rptr_q];
    OUT_DST   = dst_q[rptr_q];
    FLAG_Z    = flag_z_q;
    FLAG_C    = flag_c_q;
    FLAG_N    = flag_n_q;
    // Carry-in uses the flag before this edge so ADC chains see the previous op.
    ALU_C_IN  = (OP == ALU_SUB) ? 1'b1 :
                ((OP == ALU_ADD) && USE_CARRY) ? flag_c_q : 1'b0;
  end

  always_comb begin
    push     = IN_VALID & IN_READY;
    pop      = OUT_VALID & OUT_READY;
    data_d   = data_q;
    dst_d    = dst_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_n_d = flag_n_q;
    if (push) begin
      data_d[wptr_q] = RESULT;
      dst_d[wptr_q]  = DST;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && FLAGS_WE) begin
      flag_z_d = Z_IN;
      flag_c_d = C_IN_FLAG;
      flag_n_d = N_IN;
    end
  end

`ifdef ALU_WB_OVERFLOW_EN
  logic flag_v_q, flag_v_d;

  always_comb begin
    flag_v_d = flag_v_q;
    if (push && FLAGS_WE) begin
      case (OP)
        ALU_ADD: flag_v_d = (A_MSB == B_MSB) && (RESULT[DATA_W-1] != A_MSB);
        ALU_SUB: flag_v_d = (A_MSB != B_MSB) && (RESULT[DATA_W-1] != A_MSB);
        default: flag_v_d = 1'b0;
      endcase
    end
    FLAG_V = flag_v_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_v_q <= 1'b0;
    end else begin
      flag_v_q <= flag_v_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        dst_q[i]  <= '0;
      end
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      dst_q    <= dst_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_n_q <= flag_n_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_writeback: directed and random stimulus for alu_writeback against a |
// | queue-based reference model. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module tb_alu_writeback;

  localparam int DATA_W = 32;
  localparam int DST_W  = 5;
  localparam int DEPTH  = 2;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        op;
  logic              use_carry;
  logic              alu_c_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              z_in, c_in_flag, n_in, flags_we;
  logic [DST_W-1:0]  dst;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DST_W-1:0]  out_dst;
  logic              flag_z, flag_c, flag_n;
  logic              a_msb, b_msb;
`ifdef ALU_WB_OVERFLOW_EN
  logic              flag_v;
`endif

  alu_writeback #(.DATA_W(DATA_W), .DST_W(DST_W), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .OP(op), .USE_CARRY(use_carry), .ALU_C_IN(alu_c_in),
    .IN_VALID(in_valid), .IN_READY(in_ready), .RESULT(result), .Z_IN(z_in),
    .C_IN_FLAG(c_in_flag), .N_IN(n_in), .FLAGS_WE(flags_we), .DST(dst),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OUT_DST(out_dst),
`ifdef ALU_WB_OVERFLOW_EN
    .A_MSB(a_msb), .B_MSB(b_msb), .FLAG_V(flag_v),
`endif
    .FLAG_Z(flag_z), .FLAG_C(flag_c), .FLAG_N(flag_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DST_W-1:0]  dst;
  } entry_t;

  entry_t mq[$];
  logic   m_z, m_c, m_n, m_v;
  int     compared   = 0;
  int     mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_cin;
    if (op == OP_SUB)                     exp_cin = 1'b1;
    else if (op == OP_ADD && use_carry)   exp_cin = m_c;
    else                                  exp_cin = 1'b0;
    chk("alu_c_in", {63'd0, alu_c_in}, {63'd0, exp_cin});
    chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() != DEPTH});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("out_data", {32'd0, out_data}, {32'd0, mq[0].data});
      chk("out_dst", {59'd0, out_dst}, {59'd0, mq[0].dst});
    end
    chk("flag_z", {63'd0, flag_z}, {63'd0, m_z});
    chk("flag_c", {63'd0, flag_c}, {63'd0, m_c});
    chk("flag_n", {63'd0, flag_n}, {63'd0, m_n});
`ifdef ALU_WB_OVERFLOW_EN
    chk("flag_v", {63'd0, flag_v}, {63'd0, m_v});
`endif
  endtask

  // Check current outputs, then advance one clock and update the model.
  task automatic tick();
    bit     push, pop, r, we;
    entry_t e;
    logic   z, c, n, v;
    #1;
    check_outputs();
    r    = rst;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && (mq.size() != 0);
    we   = flags_we;
    e    = '{data: result, dst: dst};
    z = z_in; c = c_in_flag; n = n_in;
    if (op == OP_ADD)      v = (a_msb == b_msb) && (result[DATA_W-1] != a_msb);
    else if (op == OP_SUB) v = (a_msb != b_msb) && (result[DATA_W-1] != a_msb);
    else                   v = 1'b0;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      {m_z, m_c, m_n, m_v} = '0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (push && we) {m_z, m_c, m_n, m_v} = {z, c, n, v};
    end
  endtask

  task automatic set_push(input logic v, input logic [DATA_W-1:0] d, input logic [DST_W-1:0] ds);
    in_valid = v;
    result   = d;
    dst      = ds;
  endtask

  initial begin
    rst = 1'b1; op = OP_ADD; use_carry = 1'b0; in_valid = 1'b0; result = '0;
    z_in = 1'b0; c_in_flag = 1'b0; n_in = 1'b0; flags_we = 1'b0; dst = '0;
    out_ready = 1'b0; a_msb = 1'b0; b_msb = 1'b0;
    mq.delete(); {m_z, m_c, m_n, m_v} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_dst", {59'd0, out_dst}, 64'd0);
    tick();

    // Single push with flags, then ADC carry-in from stored C.
    set_push(1'b1, 32'h0, 5'd3); z_in = 1'b1; c_in_flag = 1'b1; flags_we = 1'b1;
    tick();
    set_push(1'b0, 32'h0, 5'd0); flags_we = 1'b0; z_in = 1'b0; c_in_flag = 1'b0;
    use_carry = 1'b1;
    #1;
    chk("adc_cin", {63'd0, alu_c_in}, 64'd1);
    chk("push_dst", {59'd0, out_dst}, 64'd3);
    tick();

    // Fill to full with consumer stalled; third push must be dropped.
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    set_push(1'b1, 32'h11, 5'd1); tick();
    set_push(1'b1, 32'h22, 5'd2); tick();
    #1;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    set_push(1'b1, 32'h33, 5'd4); tick();
    set_push(1'b0, 32'h0, 5'd0); tick();
    chk("stall_head", {32'd0, out_data}, 64'h11);
    out_ready = 1'b1; tick(); tick();
    #1;
    chk("drained", {63'd0, out_valid}, 64'd0);

    // Simultaneous push/pop at count 1 across pointer wrap.
    out_ready = 1'b0; set_push(1'b1, 32'h44, 5'd5); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_push(1'b1, 32'h44 + 32'(i) + 32'h1, 5'(i));
      tick();
    end
    #1;
    chk("wrap_head", {32'd0, out_data}, 64'h4C);
    set_push(1'b0, 32'h0, 5'd0); tick();

    // Push without flag write; SUB forces carry-in.
    set_push(1'b1, 32'h8000_0000, 5'd7); n_in = 1'b1; flags_we = 1'b0; tick();
    set_push(1'b0, 32'h0, 5'd0); n_in = 1'b0;
    op = OP_SUB; use_carry = 1'b0;
    #1;
    chk("sub_cin", {63'd0, alu_c_in}, 64'd1);
    chk("flag_n_held", {63'd0, flag_n}, 64'd0);
    tick();

    // Reset with two entries queued.
    op = OP_ADD; out_ready = 1'b0;
    set_push(1'b1, 32'hAA, 5'd8); flags_we = 1'b1; z_in = 1'b1; n_in = 1'b1; tick();
    set_push(1'b1, 32'hBB, 5'd9); tick();
    set_push(1'b0, 32'h0, 5'd0); flags_we = 1'b0; z_in = 1'b0; n_in = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_z", {63'd0, flag_z}, 64'd0);
    tick();

`ifdef ALU_WB_OVERFLOW_EN
    op = OP_ADD; a_msb = 1'b0; b_msb = 1'b0; flags_we = 1'b1;
    set_push(1'b1, 32'h8000_0000, 5'd1); tick();
    set_push(1'b0, 32'h0, 5'd0); flags_we = 1'b0;
    #1;
    chk("ovf_add", {63'd0, flag_v}, 64'd1);
    out_ready = 1'b1; tick();
`endif

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      op        = 3'($urandom_range(0, 7));
      use_carry = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      result    = $urandom;
      dst       = 5'($urandom);
      z_in      = 1'($urandom);
      c_in_flag = 1'($urandom);
      n_in      = 1'($urandom);
      flags_we  = 1'($urandom);
      a_msb     = 1'($urandom);
      b_msb     = 1'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
